task_launch_queue: RTL and testbench
====================================

Name: task_launch_queue

Overview:
- Per-fetcher task launch FIFO. Sits directly upstream of the instruction fetcher and drives its next_task_* interface.
- Accepts thread launch requests from the channel request arbiter. Keeps only those whose channel LSB equals QUEUE_SEL, strips that bit, and queues {channel[3:1], thread, operand} in arrival order.
- Presents the head entry show-ahead. The fetcher pops it with next_task_ack, both at task start and when a PULL consumes a same-task entry.

Parameters:
- CHAN_ID_SIZE, 4: full channel ID width on the request side.
- CHAN_SEL_SIZE, 3: stored channel width (CHAN_ID_SIZE-1).
- THREAD_SEL_SIZE, 2: thread select width. Thread 3 is reserved.
- OPERAND_SIZE, 8: launch operand width.
- DEPTH_LOG2, 3: log2 of queue depth (8 entries).
- QUEUE_SEL, 0: channel LSB value this instance accepts.

Ports:
- clk, in, 1: clock; all activity on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- req_valid, in, 1: launch request present.
- req_channel, in, CHAN_ID_SIZE: requesting channel.
- req_thread, in, THREAD_SEL_SIZE: requested thread.
- req_operand, in, OPERAND_SIZE: operand for the thread's PULL.
- req_accept, out, 1: combinational; this queue takes the request this cycle.
- req_full, out, 1: queue full (registered).
- next_task_channel, out, CHAN_SEL_SIZE: head entry channel (req_channel[3:1]).
- next_task_thread, out, THREAD_SEL_SIZE: head entry thread.
- next_task_operand, out, OPERAND_SIZE: head entry operand.
- next_task_ready, out, 1: head entry valid.
- next_task_ack, in, 1: pop head entry.
- queue_count, out, DEPTH_LOG2+1: number of valid entries.
- thread_err, out, 1: sticky; a reserved-thread request was rejected.

Behaviour:
- Reset (asynchronous, any state, including mid-push or mid-pop):
  - pointers = 0, count = 0.
  - next_task_ready = 0, req_full = 0, thread_err = 0, queue_count = 0.
  - Head data outputs are don't-care while next_task_ready = 0; the implementation drives them 0.
- Match rule: match = req_valid && req_channel[0] == QUEUE_SEL.
- req_accept = match && req_thread != 3 && !req_full.
  - Non-matching requests are ignored with req_accept = 0; they belong to the sibling queue.
  - A matching request while full is not accepted. The requester holds the request; no data is lost and there is no full-time bypass.
- Reserved thread: match with req_thread == 3 is never stored. thread_err is set the next cycle whether or not the queue is full, and stays set until reset.
- Storage: register array of 2^DEPTH_LOG2 entries, each {chan[2:0], thread, operand}.
  - wr_ptr and rd_ptr are DEPTH_LOG2 bits and wrap modulo depth.
  - count is DEPTH_LOG2+1 bits.
- Push latency: an entry accepted in cycle N is visible at the head, with next_task_ready = 1, in cycle N+1. This is the minimum empty-to-ready latency.
- Pop: next_task_ack while next_task_ready = 1 advances rd_ptr. The next head is valid in the following cycle.
  - next_task_ack while empty is ignored; count never underflows.
- Simultaneous push and pop in the same cycle: count unchanged, both pointers advance.
  - When full, req_full = 1 blocks the push even if ack is high that cycle. The push succeeds the next cycle.
  - When count = 1, the head shows the pushed entry the next cycle.
- Status flags:
  - req_full = (count == 2^DEPTH_LOG2).
  - next_task_ready = (count != 0).
  - queue_count = count.
- Order: strict FIFO. Entries are never reordered, merged or dropped once accepted.

Decomposition:
- Shared package: CHAN_SEL_SIZE, THREAD_SEL_SIZE, OPERAND_SIZE, a THREAD_RESERVED = 2'd3 constant, and a task entry typedef/width constant TASK_ENTRY_SIZE = CHAN_SEL_SIZE + THREAD_SEL_SIZE + OPERAND_SIZE. The instruction fetcher shares these.
- One natural sub-module: task_fifo_mem, the 2-D register array with write port and asynchronous read at rd_ptr. Pointer, count and flag logic stay in the top level.

Test Plan:
- Reset, then push ch=5 (LSB 1) thr=1 op=0x3C with QUEUE_SEL=1 -> req_accept=1 that cycle; next cycle next_task_ready=1, channel=2, thread=1, operand=0x3C, count=1.
- With QUEUE_SEL=0, push ch=3 (LSB 1) -> req_accept=0, count stays 0, ready stays 0.
- Push 8 matching entries op=0..7 -> req_full=1, count=8. A 9th request gets req_accept=0 until an ack; with the ack in the same cycle it is accepted one cycle later. Pops then return 0..7 in order, wrapping the pointers.
- count=1: assert push op=0xA5 and ack in the same cycle -> count stays 1, next head operand=0xA5. Ack while empty -> count stays 0.
- Matching request thr=3 -> req_accept=0, thread_err=1 next cycle, still 1 after 10 idle cycles, cleared only by reset.
- Assert reset asynchronously mid-cycle with count=5 -> ready=0, full=0, count=0 immediately, without waiting for a clock edge. The first push after reset appears at the head one cycle later.

Source files
------------

// File: rtl/task_launch_queue_pkg.sv
// Shared task-launch definitions used by the launch queue and the instruction fetcher.
// Latency: none (types, constants and a packing helper only).
// Backpressure: not applicable.
package task_launch_queue_pkg;

    localparam int CHAN_ID_SIZE       = 4;
    localparam int CHAN_SEL_SIZE      = CHAN_ID_SIZE - 1;
    localparam int THREAD_SEL_SIZE    = 2;
    localparam int OPERAND_SIZE       = 8;
    localparam int DEFAULT_DEPTH_LOG2 = 3;
    localparam int TASK_ENTRY_SIZE    = CHAN_SEL_SIZE + THREAD_SEL_SIZE + OPERAND_SIZE;

    // Thread 3 has no hardware context behind it; requests for it are rejected.
    localparam logic [THREAD_SEL_SIZE-1:0] THREAD_RESERVED = 2'd3;

    // One queued launch; the channel LSB has already been consumed by queue selection.
    typedef struct packed {
        logic [CHAN_SEL_SIZE-1:0]   chan;
        logic [THREAD_SEL_SIZE-1:0] thread;
        logic [OPERAND_SIZE-1:0]    operand;
    } task_entry_t;

    function automatic task_entry_t make_entry(
        input logic [CHAN_SEL_SIZE-1:0]   chan,
        input logic [THREAD_SEL_SIZE-1:0] thread,
        input logic [OPERAND_SIZE-1:0]    operand
    );
        task_entry_t e;
        e.chan    = chan;
        e.thread  = thread;
        e.operand = operand;
        return e;
    endfunction

endpackage

// File: rtl/task_launch_queue_if.sv
// Request-side and fetcher-side signals of one task launch queue.
// Latency: wires only.
// Backpressure: req_accept/req_full toward the arbiter, next_task_ack from the fetcher.
interface task_launch_queue_if
    import task_launch_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
);

    // Arbiter side
    logic                       req_valid;
    logic [CHAN_ID_SIZE-1:0]    req_channel;
    logic [THREAD_SEL_SIZE-1:0] req_thread;
    logic [OPERAND_SIZE-1:0]    req_operand;
    logic                       req_accept;
    logic                       req_full;

    // Fetcher side
    logic [CHAN_SEL_SIZE-1:0]   next_task_channel;
    logic [THREAD_SEL_SIZE-1:0] next_task_thread;
    logic [OPERAND_SIZE-1:0]    next_task_operand;
    logic                       next_task_ready;
    logic                       next_task_ack;

    // Status
    logic [DEPTH_LOG2:0]        queue_count;
    logic                       thread_err;

    // The environment: arbiter plus fetcher.
    modport master (
        output req_valid, req_channel, req_thread, req_operand, next_task_ack,
        input  req_accept, req_full,
        input  next_task_channel, next_task_thread, next_task_operand, next_task_ready,
        input  queue_count, thread_err
    );

    // The queue itself.
    modport slave (
        input  req_valid, req_channel, req_thread, req_operand, next_task_ack,
        output req_accept, req_full,
        output next_task_channel, next_task_thread, next_task_operand, next_task_ready,
        output queue_count, thread_err
    );

endinterface

// File: rtl/task_fifo_mem.sv
// Register-array storage for queued launch entries: one write port, async read.
// Latency: write lands at the clock edge; read is combinational from rd_ptr.
// Backpressure: none here; the caller only asserts wr_en when space exists.
module task_fifo_mem
    import task_launch_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int WIDTH      = TASK_ENTRY_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_ptr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_ptr,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem [DEPTH];

    // Entry storage; cleared on reset so stale contents never reach simulation as X.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/task_launch_queue.sv
// Per-fetcher launch FIFO: keeps requests whose channel LSB equals QUEUE_SEL, show-ahead head.
// Latency: accepted in cycle N, visible at the head in cycle N+1.
// Backpressure: req_full blocks pushes (requester holds); next_task_ack pops the head.
module task_launch_queue
    import task_launch_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter bit QUEUE_SEL  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    task_launch_queue_if.slave    q
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    ptr_t        wr_ptr;
    ptr_t        rd_ptr;
    ptr_t        wr_ptr_nxt;
    ptr_t        rd_ptr_nxt;
    cnt_t        count;
    cnt_t        count_nxt;
    logic        thread_err_q;
    logic        thread_err_nxt;

    logic        full;
    logic        not_empty;
    logic        match;
    logic        reserved;
    logic        push;
    logic        pop;

    task_entry_t                wr_entry;
    task_entry_t                head_entry;
    logic [TASK_ENTRY_SIZE-1:0] head_bits;

    // Flags come straight from the registered count.
    assign full      = (count == cnt_t'(DEPTH));
    assign not_empty = (count != '0);

    // Request decode: claim only our half of the channel space, never a reserved thread,
    // never while full. Pops with nothing queued are ignored.
    always_comb begin
        match    = 1'b0;
        reserved = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        match    = q.req_valid && (q.req_channel[0] == QUEUE_SEL);
        reserved = match && (q.req_thread == THREAD_RESERVED);
        push     = match && !reserved && !full;
        pop      = q.next_task_ack && not_empty;
    end

    // Pointer, occupancy and error-flag next state.
    always_comb begin
        wr_ptr_nxt     = wr_ptr;
        rd_ptr_nxt     = rd_ptr;
        count_nxt      = count;
        thread_err_nxt = thread_err_q;
        if (push) begin
            wr_ptr_nxt = wr_ptr + 1'b1;
        end
        if (pop) begin
            rd_ptr_nxt = rd_ptr + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
        // Sticky: set by a matching reserved-thread request even when full.
        if (reserved) begin
            thread_err_nxt = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            thread_err_q <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            thread_err_q <= thread_err_nxt;
        end
    end

    // The stored channel drops the LSB that selected this queue.
    assign wr_entry = make_entry(q.req_channel[CHAN_ID_SIZE-1:1], q.req_thread, q.req_operand);

    task_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (TASK_ENTRY_SIZE)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_ptr  (wr_ptr),
        .wr_data (wr_entry),
        .rd_ptr  (rd_ptr),
        .rd_data (head_bits)
    );

    assign head_entry = task_entry_t'(head_bits);

    // Head is show-ahead; data is forced to zero while nothing is queued.
    always_comb begin
        q.next_task_channel = '0;
        q.next_task_thread  = '0;
        q.next_task_operand = '0;
        if (not_empty) begin
            q.next_task_channel = head_entry.chan;
            q.next_task_thread  = head_entry.thread;
            q.next_task_operand = head_entry.operand;
        end
    end

    assign q.next_task_ready = not_empty;
    assign q.req_accept      = push;
    assign q.req_full        = full;
    assign q.queue_count     = count;
    assign q.thread_err      = thread_err_q;

endmodule

// File: tb/tb_task_launch_queue.sv
// Random and directed stimulus for two sibling queues (QUEUE_SEL 0 and 1) fed the same requests.
// Expected behaviour comes from a per-queue list model built from the launch rules.
// Both queues pop independently so full/empty/wrap corners are reached.
module tb_task_launch_queue;
    import task_launch_queue_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       req_valid;
    logic [3:0] req_channel;
    logic [1:0] req_thread;
    logic [7:0] req_operand;
    logic       ack [2];

    task_launch_queue_if if0 ();
    task_launch_queue_if if1 ();

    assign if0.req_valid     = req_valid;
    assign if0.req_channel   = req_channel;
    assign if0.req_thread    = req_thread;
    assign if0.req_operand   = req_operand;
    assign if0.next_task_ack = ack[0];
    assign if1.req_valid     = req_valid;
    assign if1.req_channel   = req_channel;
    assign if1.req_thread    = req_thread;
    assign if1.req_operand   = req_operand;
    assign if1.next_task_ack = ack[1];

    task_launch_queue #(.QUEUE_SEL(1'b0)) dut0 (.clk(clk), .reset(reset), .q(if0));
    task_launch_queue #(.QUEUE_SEL(1'b1)) dut1 (.clk(clk), .reset(reset), .q(if1));

    logic       acc  [2];
    logic       full [2];
    logic       rdy  [2];
    logic       err  [2];
    logic [2:0] chan [2];
    logic [1:0] thr  [2];
    logic [7:0] op   [2];
    logic [3:0] cnt  [2];

    assign acc[0]  = if0.req_accept;        assign acc[1]  = if1.req_accept;
    assign full[0] = if0.req_full;          assign full[1] = if1.req_full;
    assign rdy[0]  = if0.next_task_ready;   assign rdy[1]  = if1.next_task_ready;
    assign err[0]  = if0.thread_err;        assign err[1]  = if1.thread_err;
    assign chan[0] = if0.next_task_channel; assign chan[1] = if1.next_task_channel;
    assign thr[0]  = if0.next_task_thread;  assign thr[1]  = if1.next_task_thread;
    assign op[0]   = if0.next_task_operand; assign op[1]   = if1.next_task_operand;
    assign cnt[0]  = if0.queue_count;       assign cnt[1]  = if1.queue_count;

    // Reference model: an ordered list of {channel[3:1], thread, operand} per queue.
    typedef logic [12:0] ent_t;
    ent_t mq [2][$];
    bit   merr [2];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_match(input int i);
        return req_valid && (req_channel[0] == 1'(i));
    endfunction

    function automatic bit exp_accept(input int i);
        return is_match(i) && (req_thread != 2'd3) && (mq[i].size() < 8);
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            ent_t h;
            h = (mq[i].size() != 0) ? mq[i][0] : 13'd0;
            check($sformatf("ready%0d", i), 32'(rdy[i]),  32'(mq[i].size() != 0));
            check($sformatf("full%0d", i),  32'(full[i]), 32'(mq[i].size() == 8));
            check($sformatf("count%0d", i), 32'(cnt[i]),  32'(mq[i].size()));
            check($sformatf("chan%0d", i),  32'(chan[i]), 32'(h[12:10]));
            check($sformatf("thr%0d", i),   32'(thr[i]),  32'(h[9:8]));
            check($sformatf("op%0d", i),    32'(op[i]),   32'(h[7:0]));
            check($sformatf("err%0d", i),   32'(err[i]),  32'(merr[i]));
        end
    endtask

    // Called at a falling edge with inputs just applied; returns at the next falling edge.
    task automatic step();
        bit do_push [2];
        bit do_pop  [2];
        bit do_err  [2];
        ent_t e;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("accept%0d", i), 32'(acc[i]), 32'(exp_accept(i)));
            do_push[i] = exp_accept(i);
            do_pop[i]  = ack[i] && (mq[i].size() != 0);
            do_err[i]  = is_match(i) && (req_thread == 2'd3);
        end
        e = {req_channel[3:1], req_thread, req_operand};
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (do_pop[i])  void'(mq[i].pop_front());
            if (do_push[i]) mq[i].push_back(e);
            if (do_err[i])  merr[i] = 1'b1;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [3:0] ch, input logic [1:0] th,
                         input logic [7:0] o, input logic a0, input logic a1);
        req_valid   = v;
        req_channel = ch;
        req_thread  = th;
        req_operand = o;
        ack[0]      = a0;
        ack[1]      = a1;
    endtask

    // Reset raised between clock edges; outputs must clear before any rising edge.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            merr[i] = 1'b0;
        end
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        drive(0, 4'd0, 2'd0, 8'd0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 4'd0, 2'd0, 8'd0, 0, 0);
        merr[0] = 1'b0;
        merr[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        reset = 1'b0;

        // Odd channel lands in queue 1 only; head appears one cycle later.
        drive(1, 4'd5, 2'd1, 8'h3C, 0, 0); step();
        drive(1, 4'd3, 2'd1, 8'h11, 0, 0); step();
        drive(0, 4'd0, 2'd0, 8'h00, 0, 1); step();
        drive(0, 4'd0, 2'd0, 8'h00, 0, 1); step();

        // Fill queue 0, hold a 9th request across the full/ack boundary, then drain with wrap.
        for (int k = 0; k < 8; k++) begin
            drive(1, {3'(k), 1'b0}, 2'(k % 3), 8'(k), 0, 0); step();
        end
        drive(1, 4'd6, 2'd2, 8'h99, 0, 0); step();
        drive(1, 4'd6, 2'd2, 8'h99, 1, 0); step();
        drive(1, 4'd6, 2'd2, 8'h99, 0, 0); step();
        for (int k = 0; k < 9; k++) begin
            drive(0, 4'd0, 2'd0, 8'h00, 1, 0); step();
        end

        // Push and pop together at count 1, then pop while empty.
        drive(1, 4'd8, 2'd0, 8'h5A, 0, 0); step();
        drive(1, 4'd8, 2'd1, 8'hA5, 1, 0); step();
        drive(0, 4'd0, 2'd0, 8'h00, 1, 0); step();
        drive(0, 4'd0, 2'd0, 8'h00, 1, 1); step();

        // Reserved thread: rejected, sticky error.
        drive(1, 4'd4, 2'd3, 8'hFF, 0, 0); step();
        for (int k = 0; k < 10; k++) begin
            drive(0, 4'd0, 2'd0, 8'h00, 0, 0); step();
        end

        // Five queued, asynchronous reset, then first push after reset.
        for (int k = 0; k < 5; k++) begin
            drive(1, 4'd10, 2'd1, 8'(8'h20 + k), 0, 0); step();
        end
        async_reset();
        drive(1, 4'd2, 2'd1, 8'h42, 0, 0); step();
        drive(0, 4'd0, 2'd0, 8'h00, 0, 0); step();

        // Random traffic, alternating slow and fast drain phases.
        for (int n = 0; n < 400; n++) begin
            int ap;
            ap = (((n / 40) % 2) == 0) ? 20 : 80;
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 99) < ap), 1'($urandom_range(0, 99) < ap));
            if ($urandom_range(0, 9) == 0) req_thread = 2'd3;
            else if (req_thread == 2'd3) req_thread = 2'd0;
            step();
            if (n == 200) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
